// File: rtl/ariane_axi_soc_pkg.sv
// AXI-Lite channel bundles for the SoC configuration bus.
// 32-bit address and data.
package ariane_axi_soc;

  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespSlvErr = 2'b10;

  typedef struct packed {
    logic [31:0] addr;
    logic [2:0]  prot;
  } ax_chan_lite_t;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  strb;
  } w_chan_lite_t;

  typedef struct packed {
    logic [1:0] resp;
  } b_chan_lite_t;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  resp;
  } r_chan_lite_t;

  typedef struct packed {
    ax_chan_lite_t aw;
    logic          aw_valid;
    w_chan_lite_t  w;
    logic          w_valid;
    logic          b_ready;
    ax_chan_lite_t ar;
    logic          ar_valid;
    logic          r_ready;
  } req_lite_t;

  typedef struct packed {
    logic         aw_ready;
    logic         w_ready;
    b_chan_lite_t b;
    logic         b_valid;
    logic         ar_ready;
    r_chan_lite_t r;
    logic         r_valid;
  } resp_lite_t;

endpackage

// File: rtl/ariane_soc_pkg.sv
// TLB configuration entry layout and register word indices.
// Shared by the config register block and its consumers.
package ariane_soc;

  typedef struct packed {
    logic [31:0] first_page;
    logic [31:0] last_page;
    logic [31:0] base_page;
    logic        valid;
    logic        read_only;
  } tlb_cfg_entry_t;

  localparam logic [1:0] WordFirst = 2'd0;
  localparam logic [1:0] WordLast  = 2'd1;
  localparam logic [1:0] WordBase  = 2'd2;
  localparam logic [1:0] WordFlags = 2'd3;

endpackage

// File: rtl/axi_lite_tlb_cfg_regs.sv
// AXI-Lite register file holding TLB range entries.
// Independent single-outstanding write and read channels.
module axi_lite_tlb_cfg_regs
  import ariane_soc::*;
#(
  parameter int unsigned NumEntries       = 8,
  parameter int unsigned AxiLiteAddrWidth = 32,
  parameter int unsigned AxiLiteDataWidth = 32
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  ariane_axi_soc::req_lite_t       axi_lite_req_i,
  output ariane_axi_soc::resp_lite_t      axi_lite_resp_o,
  output tlb_cfg_entry_t [NumEntries-1:0] entries_o,
  output logic                            update_o
);

  if (AxiLiteDataWidth != 32 || NumEntries > 256 ||
      NumEntries < 1 || AxiLiteAddrWidth < 12) begin : g_bad_cfg
    $error("axi_lite_tlb_cfg_regs: illegal parameters");
  end

  typedef enum logic {W_IDLE, W_RESP} w_state_e;
  typedef enum logic {R_IDLE, R_RESP} r_state_e;

  w_state_e w_state_q, w_state_d;
  r_state_e r_state_q, r_state_d;

  tlb_cfg_entry_t [NumEntries-1:0] entries_q;
  tlb_cfg_entry_t rd_entry;

  logic [1:0]  b_resp_q;
  logic        update_q;
  logic [31:0] r_data_q;
  logic [1:0]  r_resp_q;

  logic       aw_hs, ar_hs;
  logic [7:0] w_idx, r_idx;
  logic [1:0] w_word, r_word;
  logic       w_in_range, r_in_range;
  logic       unused_bits;

  function automatic logic [31:0] merge(
    input logic [31:0] old,
    input logic [31:0] wd,
    input logic [3:0]  strb
  );
    logic [31:0] res;
    res = old;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) res[8*b +: 8] = wd[8*b +: 8];
    end
    return res;
  endfunction

  function automatic tlb_cfg_entry_t write_word(
    input tlb_cfg_entry_t e,
    input logic [1:0]     word,
    input logic [31:0]    wd,
    input logic [3:0]     strb
  );
    tlb_cfg_entry_t res;
    res = e;
    unique case (word)
      WordFirst: res.first_page = merge(e.first_page, wd, strb);
      WordLast:  res.last_page  = merge(e.last_page, wd, strb);
      WordBase:  res.base_page  = merge(e.base_page, wd, strb);
      WordFlags: begin
        // Only the two flag bits exist; both live in byte 0.
        if (strb[0]) begin
          res.valid     = wd[0];
          res.read_only = wd[1];
        end
      end
    endcase
    return res;
  endfunction

  function automatic logic [31:0] read_word(
    input tlb_cfg_entry_t e,
    input logic [1:0]     word
  );
    logic [31:0] res;
    res = '0;
    unique case (word)
      WordFirst: res = e.first_page;
      WordLast:  res = e.last_page;
      WordBase:  res = e.base_page;
      WordFlags: res = {30'b0, e.read_only, e.valid};
    endcase
    return res;
  endfunction

  assign w_idx      = axi_lite_req_i.aw.addr[11:4];
  assign w_word     = axi_lite_req_i.aw.addr[3:2];
  assign r_idx      = axi_lite_req_i.ar.addr[11:4];
  assign r_word     = axi_lite_req_i.ar.addr[3:2];
  assign w_in_range = 32'(w_idx) < NumEntries;
  assign r_in_range = 32'(r_idx) < NumEntries;

  assign aw_hs = (w_state_q == W_IDLE) &&
                 axi_lite_req_i.aw_valid &&
                 axi_lite_req_i.w_valid;
  assign ar_hs = (r_state_q == R_IDLE) &&
                 axi_lite_req_i.ar_valid;

  assign unused_bits = ^{axi_lite_req_i.aw.prot,
                         axi_lite_req_i.aw.addr[31:12],
                         axi_lite_req_i.aw.addr[1:0],
                         axi_lite_req_i.ar.prot,
                         axi_lite_req_i.ar.addr[31:12],
                         axi_lite_req_i.ar.addr[1:0]};

  always_comb begin
    rd_entry = '0;
    for (int unsigned e = 0; e < NumEntries; e++) begin
      if (32'(r_idx) == e) rd_entry = entries_q[e];
    end
  end

  always_comb begin
    w_state_d = w_state_q;
    unique case (w_state_q)
      W_IDLE: if (aw_hs) w_state_d = W_RESP;
      W_RESP: if (axi_lite_req_i.b_ready) w_state_d = W_IDLE;
    endcase
  end

  always_comb begin
    r_state_d = r_state_q;
    unique case (r_state_q)
      R_IDLE: if (ar_hs) r_state_d = R_RESP;
      R_RESP: if (axi_lite_req_i.r_ready) r_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      w_state_q <= W_IDLE;
      r_state_q <= R_IDLE;
    end else begin
      w_state_q <= w_state_d;
      r_state_q <= r_state_d;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      entries_q <= '0;
      b_resp_q  <= ariane_axi_soc::RespOkay;
      update_q  <= 1'b0;
      r_data_q  <= '0;
      r_resp_q  <= ariane_axi_soc::RespOkay;
    end else begin
      update_q <= aw_hs && w_in_range;
      if (aw_hs) begin
        b_resp_q <= w_in_range ? ariane_axi_soc::RespOkay
                               : ariane_axi_soc::RespSlvErr;
        for (int unsigned e = 0; e < NumEntries; e++) begin
          if (w_in_range && 32'(w_idx) == e) begin
            entries_q[e] <= write_word(entries_q[e], w_word,
                                       axi_lite_req_i.w.data,
                                       axi_lite_req_i.w.strb);
          end
        end
      end
      // Captured from pre-edge state, so a colliding write is not seen.
      if (ar_hs) begin
        r_data_q <= r_in_range ? read_word(rd_entry, r_word) : '0;
        r_resp_q <= r_in_range ? ariane_axi_soc::RespOkay
                               : ariane_axi_soc::RespSlvErr;
      end
    end
  end

  always_comb begin
    axi_lite_resp_o          = '0;
    axi_lite_resp_o.aw_ready = aw_hs;
    axi_lite_resp_o.w_ready  = aw_hs;
    axi_lite_resp_o.b_valid  = (w_state_q == W_RESP);
    axi_lite_resp_o.b.resp   = b_resp_q;
    axi_lite_resp_o.ar_ready = (r_state_q == R_IDLE);
    axi_lite_resp_o.r_valid  = (r_state_q == R_RESP);
    axi_lite_resp_o.r.data   = r_data_q;
    axi_lite_resp_o.r.resp   = r_resp_q;
  end

  assign entries_o = entries_q;
  assign update_o  = update_q;

endmodule

// File: tb/tb_axi_lite_tlb_cfg_regs.sv
// Directed vector bench for the TLB config register block.
// Table of write/readback vectors plus multi-cycle sequences.
module tb_axi_lite_tlb_cfg_regs;
  import ariane_soc::*;
  import ariane_axi_soc::*;

  logic clk = 1'b0;
  logic rst;
  req_lite_t req;
  resp_lite_t resp;
  tlb_cfg_entry_t [7:0] entries;
  logic update;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  axi_lite_tlb_cfg_regs #(
    .NumEntries(8),
    .AxiLiteAddrWidth(32),
    .AxiLiteDataWidth(32)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .axi_lite_req_i(req),
    .axi_lite_resp_o(resp),
    .entries_o(entries),
    .update_o(update)
  );

  typedef struct {
    logic [31:0] waddr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [31:0] raddr;
    logic [1:0]  bresp;
    logic        upd;
    logic [31:0] rdata;
    logic [1:0]  rresp;
  } vec_t;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
    end
  endtask

  task automatic do_write(input logic [31:0] addr,
                          input logic [31:0] data,
                          input logic [3:0] strb,
                          output logic [1:0] bresp,
                          output logic upd);
    @(posedge clk); #1;
    req.aw.addr  = addr;
    req.aw_valid = 1'b1;
    req.w.data   = data;
    req.w.strb   = strb;
    req.w_valid  = 1'b1;
    req.b_ready  = 1'b0;
    #1;
    check("aw_ready", 32'(resp.aw_ready), 32'd1);
    check("w_ready", 32'(resp.w_ready), 32'd1);
    @(posedge clk); #1;
    req.aw_valid = 1'b0;
    req.w_valid  = 1'b0;
    check("b_valid_lat1", 32'(resp.b_valid), 32'd1);
    bresp = resp.b.resp;
    upd   = update;
    req.b_ready = 1'b1;
    @(posedge clk); #1;
    req.b_ready = 1'b0;
    check("b_done", 32'(resp.b_valid), 32'd0);
    check("update_once", 32'(update), 32'd0);
  endtask

  task automatic do_read(input logic [31:0] addr,
                         output logic [31:0] data,
                         output logic [1:0] rresp);
    @(posedge clk); #1;
    req.ar.addr  = addr;
    req.ar_valid = 1'b1;
    req.r_ready  = 1'b0;
    #1;
    check("ar_ready", 32'(resp.ar_ready), 32'd1);
    @(posedge clk); #1;
    req.ar_valid = 1'b0;
    check("r_valid_lat1", 32'(resp.r_valid), 32'd1);
    data  = resp.r.data;
    rresp = resp.r.resp;
    req.r_ready = 1'b1;
    @(posedge clk); #1;
    req.r_ready = 1'b0;
    check("r_done", 32'(resp.r_valid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got 0x%08h want 0x%08h", 0, 1);
    $fatal(1, "timeout");
  end

  initial begin
    vec_t vecs[11];
    logic [1:0]  br, rr;
    logic        up;
    logic [31:0] rd;

    vecs[0]  = '{32'h0014, 32'hDEADBEEF, 4'hF, 32'h0014,
                 RespOkay, 1'b1, 32'hDEADBEEF, RespOkay};
    vecs[1]  = '{32'h0008, 32'h11223344, 4'hF, 32'h0008,
                 RespOkay, 1'b1, 32'h11223344, RespOkay};
    vecs[2]  = '{32'h0008, 32'hAABBCCDD, 4'h5, 32'h0008,
                 RespOkay, 1'b1, 32'h11BB33DD, RespOkay};
    vecs[3]  = '{32'h0070, 32'h12345678, 4'hF, 32'h0070,
                 RespOkay, 1'b1, 32'h12345678, RespOkay};
    vecs[4]  = '{32'h007C, 32'hFFFFFFFF, 4'hF, 32'h007C,
                 RespOkay, 1'b1, 32'h00000003, RespOkay};
    vecs[5]  = '{32'h0080, 32'hCAFEF00D, 4'hF, 32'h0080,
                 RespSlvErr, 1'b0, 32'h0, RespSlvErr};
    vecs[6]  = '{32'h0FF4, 32'h00000001, 4'hF, 32'h0FF4,
                 RespSlvErr, 1'b0, 32'h0, RespSlvErr};
    vecs[7]  = '{32'h0025, 32'h55AA55AA, 4'hF, 32'h0027,
                 RespOkay, 1'b1, 32'h55AA55AA, RespOkay};
    vecs[8]  = '{32'h0014, 32'h00000000, 4'h0, 32'h0014,
                 RespOkay, 1'b1, 32'hDEADBEEF, RespOkay};
    vecs[9]  = '{32'h007C, 32'hFFFFFFFE, 4'h1, 32'h007C,
                 RespOkay, 1'b1, 32'h00000002, RespOkay};
    vecs[10] = '{32'h1000_1014, 32'h0BADF00D, 4'hF, 32'h0014,
                 RespOkay, 1'b1, 32'h0BADF00D, RespOkay};

    req = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_b_valid", 32'(resp.b_valid), 32'd0);
    check("rst_r_valid", 32'(resp.r_valid), 32'd0);
    check("rst_update", 32'(update), 32'd0);
    check("rst_entries_zero", 32'(entries == '0), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("ar_ready_after_rst", 32'(resp.ar_ready), 32'd1);
    check("aw_ready_idle", 32'(resp.aw_ready), 32'd0);

    for (int i = 0; i < 11; i++) begin
      do_write(vecs[i].waddr, vecs[i].wdata, vecs[i].strb, br, up);
      check($sformatf("v%0d_bresp", i), 32'(br), 32'(vecs[i].bresp));
      check($sformatf("v%0d_update", i), 32'(up), 32'(vecs[i].upd));
      do_read(vecs[i].raddr, rd, rr);
      check($sformatf("v%0d_rdata", i), rd, vecs[i].rdata);
      check($sformatf("v%0d_rresp", i), 32'(rr), 32'(vecs[i].rresp));
    end

    check("e1_last", entries[1].last_page, 32'h0BADF00D);
    check("e0_base", entries[0].base_page, 32'h11BB33DD);
    check("e7_first", entries[7].first_page, 32'h12345678);
    check("e7_valid", 32'(entries[7].valid), 32'd0);
    check("e7_ro", 32'(entries[7].read_only), 32'd1);
    check("e2_last", entries[2].last_page, 32'h55AA55AA);
    check("e0_first_untouched", entries[0].first_page, 32'h0);

    // Backpressure: AW alone, then W; B and R held.
    @(posedge clk); #1;
    req.aw.addr  = 32'h0040;
    req.aw_valid = 1'b1;
    req.w.data   = 32'h600DCAFE;
    req.w.strb   = 4'hF;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("aw_alone_aw_ready", 32'(resp.aw_ready), 32'd0);
      check("aw_alone_w_ready", 32'(resp.w_ready), 32'd0);
      @(posedge clk); #1;
    end
    req.w_valid = 1'b1;
    #1;
    check("bp_aw_ready", 32'(resp.aw_ready), 32'd1);
    check("bp_w_ready", 32'(resp.w_ready), 32'd1);
    @(posedge clk); #1;
    req.aw_valid = 1'b0;
    req.w_valid  = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("bp_b_valid", 32'(resp.b_valid), 32'd1);
      check("bp_b_resp", 32'(resp.b.resp), 32'(RespOkay));
      @(posedge clk); #1;
    end
    req.b_ready = 1'b1;
    @(posedge clk); #1;
    req.b_ready = 1'b0;
    check("bp_b_done", 32'(resp.b_valid), 32'd0);

    req.ar.addr  = 32'h0040;
    req.ar_valid = 1'b1;
    #1;
    check("bp_ar_ready", 32'(resp.ar_ready), 32'd1);
    @(posedge clk); #1;
    req.ar_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("bp_r_valid", 32'(resp.r_valid), 32'd1);
      check("bp_r_data", resp.r.data, 32'h600DCAFE);
      check("bp_ar_busy", 32'(resp.ar_ready), 32'd0);
      @(posedge clk); #1;
    end
    req.r_ready = 1'b1;
    @(posedge clk); #1;
    req.r_ready = 1'b0;
    check("bp_r_done", 32'(resp.r_valid), 32'd0);

    // Collision: read sees the pre-write flags.
    @(posedge clk); #1;
    req.aw.addr  = 32'h000C;
    req.w.data   = 32'h00000003;
    req.w.strb   = 4'hF;
    req.aw_valid = 1'b1;
    req.w_valid  = 1'b1;
    req.ar.addr  = 32'h000C;
    req.ar_valid = 1'b1;
    #1;
    check("col_aw_ready", 32'(resp.aw_ready), 32'd1);
    check("col_ar_ready", 32'(resp.ar_ready), 32'd1);
    @(posedge clk); #1;
    req.aw_valid = 1'b0;
    req.w_valid  = 1'b0;
    req.ar_valid = 1'b0;
    check("col_b_valid", 32'(resp.b_valid), 32'd1);
    check("col_r_valid", 32'(resp.r_valid), 32'd1);
    check("col_rdata_old", resp.r.data, 32'h0);
    check("col_update", 32'(update), 32'd1);
    req.b_ready = 1'b1;
    req.r_ready = 1'b1;
    @(posedge clk); #1;
    req.b_ready = 1'b0;
    req.r_ready = 1'b0;
    do_read(32'h000C, rd, rr);
    check("col_rdata_new", rd, 32'h3);
    check("col_e0_valid", 32'(entries[0].valid), 32'd1);
    check("col_e0_ro", 32'(entries[0].read_only), 32'd1);

    // Reset while B is pending.
    @(posedge clk); #1;
    req.aw.addr  = 32'h0030;
    req.w.data   = 32'h00000077;
    req.w.strb   = 4'hF;
    req.aw_valid = 1'b1;
    req.w_valid  = 1'b1;
    @(posedge clk); #1;
    req.aw_valid = 1'b0;
    req.w_valid  = 1'b0;
    check("rst_pend_b_valid", 32'(resp.b_valid), 32'd1);
    rst = 1'b1;
    #1;
    check("rst_drop_b_valid", 32'(resp.b_valid), 32'd0);
    check("rst_drop_update", 32'(update), 32'd0);
    check("rst_all_zero", 32'(entries == '0), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    req.b_ready = 1'b1;
    #1;
    check("rst2_ar_ready", 32'(resp.ar_ready), 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("rst_no_b", 32'(resp.b_valid), 32'd0);
    end
    req.b_ready = 1'b0;
    do_read(32'h0014, rd, rr);
    check("rst_read_zero", rd, 32'h0);
    check("rst_read_resp", 32'(rr), 32'(RespOkay));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
